tt_um_led_pattern_monitor: RTL and testbench
============================================

Name: tt_um_led_pattern_monitor

Overview:
Receive-side companion to the LED pattern generator. Samples an 8-bit LED bus on ui_in and classifies the bus against the four generator pattern modes. The modes are binary counter, Knight Rider, LFSR and alternating 55/AA. Drives mode, lock, mismatch and stall status on uo_out. Used on the test board to check a generator tile pin-to-pin.

Parameters:
LOCK_COUNT, 4, consecutive matching steps needed to declare lock (legal 1..7)
TIMEOUT, 64, quiet cycles (no bus change) before the monitor declares a stall
TIMEOUT_W, 8, width of the quiet-cycle counter; TIMEOUT < 2^TIMEOUT_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  enable; when low, all state is frozen and nothing is sampled
ui_in  in  8  observed LED bus, asynchronous to clk
uo_out  out  8  [1:0] mode, [2] locked, [3] mismatch_sticky, [4] stalled, [7:5] match count of the reported mode
uio_in  in  8  [0] clear_mismatch (synchronous, active high); [7:1] unused
uio_out  out  8  constant 0
uio_oe  out  8  constant 0

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: every register is 0, so uo_out = 0x00. FSM is IDLE.
- Input path:
  - ui_in passes through a 2-flop synchronizer (sync).
  - prev holds the last sync value and loads every enabled cycle.
  - A change is sync != prev.
- Latency: an edge on ui_in reaches uo_out 3 clk edges later: 2 synchronizer edges plus 1 status edge.
- Step predicates, evaluated on each change with p = prev and n = sync:
  - M0 counter: n == p+1, mod 256.
  - M1 knight:
    - p in {00, 80} requires n = 01.
    - p < 80 requires n = p<<1.
    - Otherwise requires n = p>>1.
  - M2 LFSR:
    - p == 00 requires n = 01.
    - Otherwise requires n = {p[6:0], p7^p5^p4^p3}.
  - M3 alternating: p == 55 requires n = AA; otherwise requires n = 55.
- Match counters cnt[0..3], 3 bits each:
  - On a change, a matching mode saturates-increments at 7.
  - A non-matching mode clears to 0.
  - No change leaves the counters unchanged.
- Reported mode:
  - LOCKED reports the locked mode.
  - Otherwise, argmax of cnt; ties go to the lowest index.
  - IDLE reports mode 0 with count 0.
- FSM states IDLE, TRACK, LOCKED. Transitions:
  - IDLE → TRACK on the first change; predicates are evaluated on that change.
  - TRACK → LOCKED on the change after which any cnt >= LOCK_COUNT. The locked mode is the lowest qualifying index.
  - LOCKED → TRACK on a change that fails the locked mode's predicate. That change sets mismatch_sticky.
  - LOCKED self-loops on matching changes.
  - TRACK or LOCKED → IDLE when the quiet counter reaches TIMEOUT. This clears all cnt and sets stalled.
- Quiet counter:
  - Clears on every change.
  - Otherwise increments, saturating.
  - Inactive in IDLE.
- stalled clears on the next change.
- mismatch_sticky:
  - Clears only on reset or when uio_in[0] = 1.
  - If a set and a clear occur in the same cycle, set wins.
- ena = 0: the synchronizer, prev, counters and FSM all hold. Outputs hold.
- Reset mid-operation: asynchronous, so uo_out returns to 0 immediately.

Decomposition:
- Shared package led_pattern_pkg:
  - Mode encodings: MODE_COUNT=0, MODE_KNIGHT=1, MODE_LFSR=2, MODE_ALT=3.
  - ALT_A=8'h55, ALT_B=8'h AA.
  - LFSR tap positions.
  - Generator step period (16).
- The generator imports the same package.
- One sub-module, led_step_predict: combinational next-value function, (mode, p) → expected n. It is instantiated 4× here and is reusable by the generator.

Test Plan:
1. Counter bus 00,01,02,03,04, 16 cycles each: lock on the 03→04 change. uo_out = {100, 0, 0, 1, 00} = 0x84, 3 cycles after the edge.
2. Knight bus 01,02,04,08,10: M0 fails at 02→04 and M2 fails at 08→10. Locked mode = 01.
3. LFSR bus 01,02,04,08,11,23: lock at 08→11 with mode = 10. 11→23 keeps the lock and the count goes to 5.
4. Alternating 55,AA,55,AA,55 then 12:
   - Locked at mode 11.
   - On 12: locked = 0 and mismatch = 1, sticky while uio_in[0] = 0.
   - Pulse uio_in[0] clears mismatch.
5. Lock in mode 00, then hold the bus constant for 64 cycles: IDLE, stalled = 1, locked = 0, count = 0. The next change clears stalled and the FSM enters TRACK.
6. ena = 0 across two bus steps: uo_out unchanged. rst_n low while locked: uo_out = 0x00 asynchronously.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator and monitor tiles:
// mode encodings, pattern constants and the LFSR step function.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_KNIGHT = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_ALT    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_t;

  localparam int NUM_MODES = 4;

  // Alternating pattern values
  localparam logic [7:0] ALT_A = 8'h55;
  localparam logic [7:0] ALT_B = 8'hAA;

  // Knight Rider turns around at the top bit
  localparam logic [7:0] KNIGHT_TOP = 8'h80;

  // LFSR feedback taps: bits 7, 5, 4 and 3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Clock cycles between generator steps
  localparam int STEP_PERIOD = 16;

  // One LFSR step; the all-zero lockup state is kicked back to 01
  function automatic logic [7:0] lfsr_next(input logic [7:0] p);
    logic [7:0] n;
    if (p == 8'h00) begin
      n = 8'h01;
    end else begin
      n = {p[6:0], ^(p & LFSR_TAPS)};
    end
    return n;
  endfunction

endpackage

// File: rtl/led_step_predict.sv
// Combinational next-value model of one pattern mode: given the current
// bus value p, produce the value the generator would show next.
module led_step_predict
  import led_pattern_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [7:0] p,
  output logic [7:0] n
);

  // Select the step rule for the requested mode
  always_comb begin
    n = 8'h00;
    case (mode)
      MODE_COUNT: n = p + 8'd1;
      MODE_KNIGHT: begin
        if ((p == 8'h00) || (p == KNIGHT_TOP)) begin
          n = 8'h01;
        end else if (p < KNIGHT_TOP) begin
          n = {p[6:0], 1'b0};
        end else begin
          n = {1'b0, p[7:1]};
        end
      end
      MODE_LFSR: n = lfsr_next(p);
      MODE_ALT:  n = (p == ALT_A) ? ALT_B : ALT_A;
      default:   n = 8'h00;
    endcase
  end

endmodule

// File: rtl/tt_um_led_pattern_monitor.sv
// Receive-side LED pattern monitor: synchronises the LED bus, scores every
// bus change against the four generator modes and reports mode, lock,
// mismatch and stall status.
module tt_um_led_pattern_monitor
  import led_pattern_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64,
  parameter int TIMEOUT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [7:0] prev_q, prev_d;

  logic [NUM_MODES-1:0][2:0] cnt_q, cnt_d, cnt_upd;
  logic [NUM_MODES-1:0][7:0] expect_n;
  logic [NUM_MODES-1:0]      match;

  mon_state_t           state_q, state_d;
  logic [1:0]           lock_mode_q, lock_mode_d;
  logic                 mismatch_q, mismatch_d;
  logic                 stalled_q, stalled_d;
  logic [TIMEOUT_W-1:0] quiet_q, quiet_d;

  logic       change;
  logic       lock_hit;
  logic [1:0] lock_pick;
  logic [1:0] best_mode;
  logic [1:0] rep_mode;
  logic [2:0] rep_cnt;
  logic       unused_uio;

  assign unused_uio = &{1'b0, uio_in[7:1]};

  // Input synchroniser and previous-value register, frozen while disabled
  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    prev_d  = prev_q;
    if (ena) begin
      sync1_d = ui_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
    end
  end

  assign change = ena && (sync2_q != prev_q);

  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_predict
    led_step_predict u_predict (
      .mode (2'(gi)),
      .p    (prev_q),
      .n    (expect_n[gi])
    );
    assign match[gi] = (sync2_q == expect_n[gi]);
  end

  // Per-mode match counters as they would stand after the current change
  always_comb begin
    cnt_upd   = cnt_q;
    lock_hit  = 1'b0;
    lock_pick = 2'd0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (match[i]) begin
        cnt_upd[i] = (cnt_q[i] == 3'd7) ? 3'd7 : cnt_q[i] + 3'd1;
      end else begin
        cnt_upd[i] = 3'd0;
      end
    end
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (cnt_upd[i] >= 3'(LOCK_COUNT)) begin
        lock_hit  = 1'b1;
        lock_pick = 2'(i);
      end
    end
  end

  // Tracking FSM with quiet-timeout, stall and sticky mismatch handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_mode_d = lock_mode_q;
    mismatch_d  = mismatch_q;
    stalled_d   = stalled_q;
    quiet_d     = quiet_q;
    if (ena) begin
      if (uio_in[0]) begin
        mismatch_d = 1'b0;
      end
      if (change) begin
        cnt_d     = cnt_upd;
        quiet_d   = '0;
        stalled_d = 1'b0;
        case (state_q)
          ST_IDLE: state_d = ST_TRACK;
          ST_TRACK: begin
            if (lock_hit) begin
              state_d     = ST_LOCKED;
              lock_mode_d = lock_pick;
            end
          end
          ST_LOCKED: begin
            if (!match[lock_mode_q]) begin
              state_d    = ST_TRACK;
              mismatch_d = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (quiet_q >= TIMEOUT_W'(TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          stalled_d = 1'b1;
          quiet_d   = '0;
        end else if (quiet_q != '1) begin
          quiet_d = quiet_q + TIMEOUT_W'(1);
        end
      end
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      lock_mode_q <= 2'd0;
      mismatch_q  <= 1'b0;
      stalled_q   <= 1'b0;
      quiet_q     <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      lock_mode_q <= lock_mode_d;
      mismatch_q  <= mismatch_d;
      stalled_q   <= stalled_d;
      quiet_q     <= quiet_d;
    end
  end

  // Reported mode: locked mode, else highest count with ties to lowest index
  always_comb begin
    best_mode = 2'd0;
    for (int i = 1; i < NUM_MODES; i++) begin
      if (cnt_q[i] > cnt_q[best_mode]) begin
        best_mode = 2'(i);
      end
    end
    rep_mode = 2'd0;
    rep_cnt  = 3'd0;
    case (state_q)
      ST_LOCKED: begin
        rep_mode = lock_mode_q;
        rep_cnt  = cnt_q[lock_mode_q];
      end
      ST_TRACK: begin
        rep_mode = best_mode;
        rep_cnt  = cnt_q[best_mode];
      end
      default: begin
        rep_mode = 2'd0;
        rep_cnt  = 3'd0;
      end
    endcase
  end

  assign uo_out  = {rep_cnt, stalled_q, mismatch_q, (state_q == ST_LOCKED), rep_mode};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_led_pattern_monitor.sv
// Directed self-checking bench for the LED pattern monitor.
module tb_tt_um_led_pattern_monitor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int passed = 0;

  tt_um_led_pattern_monitor #(
    .LOCK_COUNT (4),
    .TIMEOUT    (64),
    .TIMEOUT_W  (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the bus on a falling edge, then let it settle for some cycles
  task automatic applyStimulus(input logic [7:0] bus, input int cycles);
    ui_in = bus;
    repeat (cycles) @(negedge clk);
  endtask

  // Compare an observed value against the hand-computed expectation
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  // Reset with the bus at zero, release on a falling edge
  task automatic doReset();
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Directed sequence
  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_uo", uo_out, 8'h00);
    checkOutput("reset_uio_out", uio_out, 8'h00);
    checkOutput("reset_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Counter pattern, lock on 03->04 with three-edge latency
    applyStimulus(8'h01, 16);
    applyStimulus(8'h02, 16);
    applyStimulus(8'h03, 16);
    checkOutput("cnt_track3", uo_out, 8'h60);
    applyStimulus(8'h04, 2);
    checkOutput("cnt_latency2", uo_out, 8'h60);
    applyStimulus(8'h04, 1);
    checkOutput("cnt_lock", uo_out, 8'h84);
    applyStimulus(8'h04, 13);

    // Knight Rider; knight and LFSR tie before lock, lowest index wins
    doReset();
    applyStimulus(8'h01, 16);
    applyStimulus(8'h02, 16);
    applyStimulus(8'h04, 16);
    checkOutput("knight_tie", uo_out, 8'h61);
    applyStimulus(8'h08, 16);
    checkOutput("knight_lock", uo_out, 8'h85);
    applyStimulus(8'h10, 16);
    checkOutput("knight_cnt5", uo_out, 8'hA5);

    // LFSR, preceded by an unrelated value so 01 arrives with no matches
    doReset();
    applyStimulus(8'h33, 16);
    applyStimulus(8'h01, 16);
    applyStimulus(8'h02, 16);
    applyStimulus(8'h04, 16);
    applyStimulus(8'h08, 16);
    checkOutput("lfsr_tie", uo_out, 8'h61);
    applyStimulus(8'h11, 16);
    checkOutput("lfsr_lock", uo_out, 8'h86);
    applyStimulus(8'h23, 16);
    checkOutput("lfsr_cnt5", uo_out, 8'hA6);

    // Alternating, then a break that sets the sticky mismatch
    doReset();
    applyStimulus(8'h55, 16);
    applyStimulus(8'hAA, 16);
    applyStimulus(8'h55, 16);
    applyStimulus(8'hAA, 16);
    checkOutput("alt_lock", uo_out, 8'h87);
    applyStimulus(8'h55, 16);
    checkOutput("alt_cnt5", uo_out, 8'hA7);
    applyStimulus(8'h12, 16);
    checkOutput("alt_mismatch", uo_out, 8'h08);
    applyStimulus(8'h12, 20);
    checkOutput("alt_sticky", uo_out, 8'h08);
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    checkOutput("alt_clear", uo_out, 8'h00);

    // Counter lock, then quiet bus until the stall timeout
    doReset();
    applyStimulus(8'h01, 16);
    applyStimulus(8'h02, 16);
    applyStimulus(8'h03, 16);
    applyStimulus(8'h04, 16);
    checkOutput("stall_locked", uo_out, 8'h84);
    applyStimulus(8'h04, 40);
    checkOutput("stall_not_yet", uo_out, 8'h84);
    applyStimulus(8'h04, 20);
    checkOutput("stall_idle", uo_out, 8'h10);
    applyStimulus(8'h05, 16);
    checkOutput("stall_resume", uo_out, 8'h20);

    // Enable low freezes everything; reset while locked clears at once
    doReset();
    applyStimulus(8'h01, 16);
    applyStimulus(8'h02, 16);
    applyStimulus(8'h03, 16);
    applyStimulus(8'h04, 16);
    ena = 1'b0;
    applyStimulus(8'h05, 8);
    applyStimulus(8'h06, 8);
    checkOutput("ena_hold", uo_out, 8'h84);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", uo_out, 8'h00);
    ena   = 1'b1;
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
